// File: rtl/histogram_equalizer_lut.sv
`default_nettype none
// ============================================================================
// Module   : histogram_equalizer_lut
// Brief    : Builds a CDF mapping LUT from a 256-bin histogram into a shadow
//            bank and applies the active bank to the pixel stream. The banks
//            swap at the end_of_frame falling edge. The optional per-bin clip
//            is enabled by defining HEQ_CLIP_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module histogram_equalizer_lut #(
    parameter int FRAME_PIXELS_LOG2 = 16
`ifdef HEQ_CLIP_LIMIT_EN
    ,
    parameter int CLIP_LIMIT        = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hist_valid,
    output logic [7:0]  hist_addr_rd,
    input  logic [15:0] hist_data_rd,
    input  logic [7:0]  in_pixel,
    input  logic        in_valid,
    input  logic        end_of_frame,
    output logic [7:0]  out_pixel,
    output logic        out_valid,
    output logic        out_end_of_frame,
    output logic        lut_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [23:0] r_cdf;
    logic        r_rd_valid;
    logic [7:0]  r_bin_idx;
    logic        r_pending;
    logic        r_active;
    logic        r_eof_prev;

    logic [7:0]  r_pix1;
    logic        r_vld1;
    logic        r_eof1;

    // Two banks of 256 entries, addressed as {bank, index}
    logic [7:0]  r_lut [0:511];

    logic [15:0] w_bin;
    logic [23:0] w_cdf_next;
    logic [31:0] w_prod;
    logic [31:0] w_scaled;
    logic [7:0]  w_map;
    logic        w_fall;
    logic        w_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (hist_valid) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (hist_addr_rd == 8'd255) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address sweep holds at 255 once issued so the sweep happens exactly once
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_addr_rd <= 8'd0;
            r_cdf        <= 24'd0;
            r_rd_valid   <= 1'b0;
            r_bin_idx    <= 8'd0;
        end else begin
            r_rd_valid <= (r_state == S_READ);
            r_bin_idx  <= hist_addr_rd;
            if ((r_state == S_IDLE) && hist_valid) begin
                hist_addr_rd <= 8'd0;
                r_cdf        <= 24'd0;
            end else begin
                if ((r_state == S_READ) && (hist_addr_rd != 8'd255)) begin
                    hist_addr_rd <= hist_addr_rd + 8'd1;
                end
                if (r_rd_valid) begin
                    r_cdf <= w_cdf_next;
                end
            end
        end
    end

`ifdef HEQ_CLIP_LIMIT_EN
    localparam logic [15:0] c_clip = 16'(CLIP_LIMIT);
    assign w_bin = (hist_data_rd > c_clip) ? c_clip : hist_data_rd;
`else
    assign w_bin = hist_data_rd;
`endif

    assign w_cdf_next = r_cdf + {8'd0, w_bin};
    assign w_prod     = {8'd0, w_cdf_next} * 32'd255;
    assign w_scaled   = w_prod >> FRAME_PIXELS_LOG2;
    assign w_map      = (w_scaled > 32'd255) ? 8'd255 : w_scaled[7:0];

    always_ff @(posedge clk) begin
        if (r_rd_valid) begin
            r_lut[{~r_active, r_bin_idx}] <= w_map;
        end
    end

    // Swap uses the pre-edge pending, so a LUT finishing on the boundary waits
    assign w_fall = r_eof_prev & ~end_of_frame;
    assign w_swap = w_fall & r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eof_prev <= 1'b0;
            r_pending  <= 1'b0;
            r_active   <= 1'b0;
            lut_ready  <= 1'b0;
        end else begin
            r_eof_prev <= end_of_frame;
            if (w_swap) begin
                r_active  <= ~r_active;
                lut_ready <= 1'b1;
                r_pending <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix1           <= 8'd0;
            r_vld1           <= 1'b0;
            r_eof1           <= 1'b0;
            out_pixel        <= 8'd0;
            out_valid        <= 1'b0;
            out_end_of_frame <= 1'b0;
        end else begin
            r_pix1           <= in_pixel;
            r_vld1           <= in_valid;
            r_eof1           <= end_of_frame;
            out_pixel        <= lut_ready ? r_lut[{r_active, r_pix1}] : r_pix1;
            out_valid        <= r_vld1;
            out_end_of_frame <= r_eof1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_equalizer_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_equalizer_lut
// Brief    : Scoreboard bench for histogram_equalizer_lut with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_histogram_equalizer_lut;

`ifdef HEQ_CLIP_LIMIT_EN
    localparam logic [7:0] c_skew_mid = 8'd3;
    localparam logic [7:0] c_skew_top = 8'd3;
`else
    localparam logic [7:0] c_skew_mid = 8'd254;
    localparam logic [7:0] c_skew_top = 8'd255;
`endif

    logic        clk;
    logic        rst;
    logic        hist_valid;
    logic [7:0]  hist_addr_rd;
    logic [15:0] hist_data_rd;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        end_of_frame;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic        out_end_of_frame;
    logic        lut_ready;
    logic        busy;

    logic [15:0] hist_mem [0:255];
    int          checks;
    int          errors;
    int          cyc;

    typedef struct {
        logic [7:0] pix;
        logic       eof;
        int         at;
    } exp_t;
    exp_t sb[$];

    histogram_equalizer_lut dut (
        .clk              (clk),
        .rst              (rst),
        .hist_valid       (hist_valid),
        .hist_addr_rd     (hist_addr_rd),
        .hist_data_rd     (hist_data_rd),
        .in_pixel         (in_pixel),
        .in_valid         (in_valid),
        .end_of_frame     (end_of_frame),
        .out_pixel        (out_pixel),
        .out_valid        (out_valid),
        .out_end_of_frame (out_end_of_frame),
        .lut_ready        (lut_ready),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Histogram memory with one cycle of read latency
    always @(posedge clk) hist_data_rd <= hist_mem[hist_addr_rd];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] pix, input logic [7:0] exp_pix);
        exp_t e;
        e.pix = exp_pix;
        e.eof = end_of_frame;
        e.at  = cyc + 2;
        sb.push_back(e);
        in_pixel = pix;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: out_pixel %0d with nothing expected", out_pixel);
            end else begin
                e = sb.pop_front();
                chk("sb_pixel", int'(out_pixel), int'(e.pix));
                chk("sb_eof", int'(out_end_of_frame), int'(e.eof));
                chk("sb_latency_cycle", cyc, e.at);
            end
        end
    end

    initial begin : stim
        int busy_cnt;
        int zero_cnt;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst          = 1'b1;
        hist_valid   = 1'b0;
        in_pixel     = 8'd0;
        in_valid     = 1'b0;
        end_of_frame = 1'b0;
        busy_cnt     = 0;
        zero_cnt     = 0;
        for (int i = 0; i < 256; i++) hist_mem[i] = 16'd256;

        repeat (4) tick;
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_eof", int'(out_end_of_frame), 0);
        chk("rst_hist_addr", int'(hist_addr_rd), 0);
        chk("rst_lut_ready", int'(lut_ready), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick;

        // Bypass before any LUT is active
        send(8'd37, 8'd37);
        chk("bypass_lut_ready", int'(lut_ready), 0);
        send(8'd200, 8'd200);
        end_of_frame = 1'b1;
        send(8'd3, 8'd3);
        end_of_frame = 1'b0;
        repeat (3) tick;

        // Uniform build; a second hist_valid mid-build must be ignored
        hist_valid = 1'b1;
        tick;
        hist_valid = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (busy) busy_cnt++;
            if (busy && (hist_addr_rd == 8'd0)) zero_cnt++;
            hist_valid = (i == 100);
            tick;
        end
        hist_valid = 1'b0;
        chk("build_busy_cycles", busy_cnt, 258);
        chk("build_addr0_sweeps", zero_cnt, 1);
        chk("lut_ready_before_swap", int'(lut_ready), 0);
        end_of_frame = 1'b1;
        tick;
        end_of_frame = 1'b0;
        tick;
        chk("lut_ready_after_swap", int'(lut_ready), 1);
        send(8'd0, 8'd0);
        send(8'd100, 8'd100);
        send(8'd255, 8'd255);
        send(8'd10, 8'd10);
        repeat (3) tick;

        // Skewed build; boundary coincides with pending rising, so no swap
        for (int i = 0; i < 256; i++) hist_mem[i] = 16'd0;
        hist_mem[10]  = 16'd65535;
        hist_mem[200] = 16'd1;
        hist_valid = 1'b1;
        tick;
        hist_valid = 1'b0;
        repeat (100) tick;
        send(8'd5, 8'd5);
        send(8'd200, 8'd200);
        repeat (154) tick;
        end_of_frame = 1'b1;
        tick;
        end_of_frame = 1'b0;
        send(8'd10, 8'd10);
        send(8'd255, 8'd255);
        repeat (3) tick;

        // Next boundary swaps to the skewed LUT from the first pixel after it
        end_of_frame = 1'b1;
        send(8'd100, 8'd100);
        end_of_frame = 1'b0;
        send(8'd10, c_skew_mid);
        send(8'd0, 8'd0);
        send(8'd9, 8'd0);
        send(8'd199, c_skew_mid);
        send(8'd200, c_skew_top);
        send(8'd255, c_skew_top);
        repeat (4) tick;
        chk("lut_ready_skew", int'(lut_ready), 1);

        // Reset in the middle of a build
        hist_valid = 1'b1;
        tick;
        hist_valid = 1'b0;
        repeat (149) tick;
        chk("midbuild_busy", int'(busy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_lut_ready", int'(lut_ready), 0);
        end_of_frame = 1'b1;
        tick;
        end_of_frame = 1'b0;
        tick;
        chk("no_swap_after_reset", int'(lut_ready), 0);
        send(8'd77, 8'd77);
        send(8'd254, 8'd254);
        repeat (4) tick;
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
